// File: rtl/cache_arbiter_if.sv
// Bundles the I-cache, D-cache and downstream line-transfer signals of the cache arbiter.
// Latency: none (wires only).
// Backpressure: requests stay high until a resp pulse; downstream completes with mem_resp.
interface cache_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    // I-cache side
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    // D-cache side
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    // Downstream (write-eviction buffer) side
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    logic              grant_d;

    // Arbiter view
    modport slave (
        input  i_read, i_address,
        input  d_read, d_write, d_address, d_wdata,
        input  mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
        output mem_read, mem_write, mem_address, mem_wdata,
        output grant_d
    );

    // Environment view: requesters plus downstream memory
    modport master (
        output i_read, i_address,
        output d_read, d_write, d_address, d_wdata,
        output mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
        input  mem_read, mem_write, mem_address, mem_wdata,
        input  grant_d
    );
endinterface

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto one downstream port, D preferred with a starvation cap.
// Latency: mem request 1 cycle after grant decision; resp/rdata combinational from mem_resp; 1 IDLE cycle between jobs.
// Backpressure: a granted access is held until mem_resp; the losing requester simply waits with its request high.
module cache_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int LINE_W       = 256,
    parameter int MAX_D_STREAK = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    cache_arbiter_if.slave bus
);
    localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t            state;
    logic [SW-1:0]     d_streak;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              rd_q;
    logic              wr_q;
    logic [LINE_W-1:0] i_rdata_q;
    logic [LINE_W-1:0] d_rdata_q;

    logic d_req;
    logic pick_d;

    // D wins a tie unless it has already taken MAX_D_STREAK grants in a row while I waited
    assign d_req  = bus.d_read | bus.d_write;
    assign pick_d = d_req & ~(bus.i_read & (d_streak == STREAK_MAX));

    // Arbitration FSM: latches the winner's request on leaving IDLE and holds it until mem_resp
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            d_streak  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_read || d_req) begin
                        if (pick_d) begin
                            state   <= SERVE_D;
                            addr_q  <= bus.d_address;
                            wdata_q <= bus.d_wdata;
                            // a simultaneous read+write request is treated as a write
                            wr_q    <= bus.d_write;
                            rd_q    <= ~bus.d_write;
                            if (!bus.i_read) begin
                                d_streak <= '0;
                            end else if (d_streak != STREAK_MAX) begin
                                d_streak <= d_streak + 1'b1;
                            end
                        end else begin
                            state    <= SERVE_I;
                            addr_q   <= bus.i_address;
                            wdata_q  <= '0;
                            rd_q     <= 1'b1;
                            wr_q     <= 1'b0;
                            d_streak <= '0;
                        end
                    end
                end
                SERVE_I: begin
                    if (bus.mem_resp) begin
                        state     <= IDLE;
                        rd_q      <= 1'b0;
                        wr_q      <= 1'b0;
                        i_rdata_q <= bus.mem_rdata;
                    end
                end
                SERVE_D: begin
                    if (bus.mem_resp) begin
                        state     <= IDLE;
                        rd_q      <= 1'b0;
                        wr_q      <= 1'b0;
                        d_rdata_q <= bus.mem_rdata;
                    end
                end
                default: begin
                    state <= IDLE;
                    rd_q  <= 1'b0;
                    wr_q  <= 1'b0;
                end
            endcase
        end
    end

    // Downstream request comes only from the latches, so requester changes mid-grant are invisible
    assign bus.mem_read    = rd_q;
    assign bus.mem_write   = wr_q;
    assign bus.mem_address = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.grant_d     = (state == SERVE_D);

    // Completion passes straight through; mem_resp outside a grant is dropped
    assign bus.i_resp  = (state == SERVE_I) & bus.mem_resp;
    assign bus.d_resp  = (state == SERVE_D) & bus.mem_resp;
    assign bus.i_rdata = (state == SERVE_I) ? bus.mem_rdata : i_rdata_q;
    assign bus.d_rdata = (state == SERVE_D) ? bus.mem_rdata : d_rdata_q;
endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width.
REQ-002 SHALL have parameter LINE_W, default 256: cache line width.
REQ-003 SHALL have parameter MAX_D_STREAK, default 4: maximum consecutive D grants while I waits.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port i_read, input, 1: I-cache line read request.
REQ-007 SHALL have port i_address, input, ADDR_W: I-cache line address.
REQ-008 SHALL have port i_rdata, output, LINE_W: line returned to the I-cache.
REQ-009 SHALL have port i_resp, output, 1: I-cache completion pulse.
REQ-010 SHALL have ports d_read and d_write, input, 1 each: D-cache line read or write request.
REQ-011 SHALL have ports d_address (ADDR_W) and d_wdata (LINE_W), input: D-cache address and write line.
REQ-012 SHALL have ports d_rdata (LINE_W) and d_resp (1), output: D-cache returned line and completion pulse.
REQ-013 SHALL have ports mem_read and mem_write, output, 1 each: downstream request to the write-eviction buffer.
REQ-014 SHALL have ports mem_address (ADDR_W) and mem_wdata (LINE_W), output: downstream address and write data.
REQ-015 SHALL have ports mem_rdata (LINE_W) and mem_resp (1), input: downstream read data and completion.
REQ-016 SHALL have port grant_d, output, 1: high while the D-cache owns downstream.

Function
REQ-017 SHALL implement states IDLE, SERVE_I and SERVE_D.
REQ-018 IDLE with no request SHALL remain in IDLE and drive all mem_* control low.
REQ-019 IDLE with only i_read SHALL go to SERVE_I, and with only d_read or d_write SHALL go to SERVE_D.
REQ-020 IDLE with both requesting SHALL choose SERVE_D unless d_streak == MAX_D_STREAK, in which case it SHALL choose SERVE_I.
REQ-021 d_streak SHALL increment on each SERVE_D entry while i_read is high, saturate at MAX_D_STREAK, and clear on SERVE_I entry or on SERVE_D entry with i_read low.
REQ-022 On leaving IDLE, the arbiter SHALL latch the granted address, write data and operation into registers; mem_address, mem_wdata, mem_read and mem_write SHALL drive from these latches only.
REQ-023 If d_read and d_write are both high, the arbiter SHALL latch write.
REQ-024 In SERVE_x, the latched mem_read or mem_write SHALL stay high until mem_resp.
REQ-025 In SERVE_x, x_resp SHALL equal mem_resp combinationally, and x_rdata SHALL equal mem_rdata.
REQ-026 When not serving, i_rdata and d_rdata SHALL hold the last captured value.
REQ-027 On mem_resp, SERVE_x SHALL return to IDLE, with zero latency to the requester beyond downstream.
REQ-028 Request-to-mem_read/mem_write latency SHALL be exactly 1 cycle from IDLE.
REQ-029 After each transaction, the arbiter SHALL spend at least 1 IDLE cycle.
REQ-030 Requesters deassert the cycle after resp; a request still high in IDLE SHALL be treated as a new request.
REQ-031 A requester dropping its request mid-grant SHALL NOT abort the transaction: the downstream access completes and the resp pulse is still issued.
REQ-032 mem_resp in IDLE SHALL be ignored, with no resp to either requester.
REQ-033 grant_d SHALL be high exactly in SERVE_D.
REQ-034 Only one of i_resp and d_resp SHALL be high in any cycle, and mem_read and mem_write SHALL never be high together.

Reset
REQ-035 rst_n low SHALL immediately force IDLE, d_streak 0, and latched address/data/op to 0.
REQ-036 rst_n low SHALL force all outputs to 0, including mem_read, mem_write, i_resp, d_resp, grant_d, i_rdata and d_rdata.
REQ-037 Reset mid-transaction SHALL abandon the downstream access; a mem_resp arriving afterwards SHALL be ignored per REQ-032.
REQ-038 The first grant SHALL be possible in the first clock edge after rst_n rises.

Verification
REQ-039 Scenario: i_read=1, i_address=0x0000_1000; mem_resp after 3 cycles with mem_rdata=0xA5..A5 -> mem_read high 1 cycle after request, mem_address=0x1000; i_resp single pulse coincident with mem_resp; i_rdata=0xA5..A5; d_resp stays 0.
REQ-040 Scenario: i_read and d_write assert in the same cycle, d_address=0x2000 -> D served first with mem_write=1 and mem_address=0x2000; I served next, after one IDLE cycle.
REQ-041 Scenario: d_read held continuously through 5 back-to-back transactions while i_read is held -> D granted 4 times, then I, then D; d_streak returns to 0 after the I grant.
REQ-042 Scenario: d_address changes from 0x3000 to 0x4000 mid-SERVE_D -> mem_address stays 0x3000 until mem_resp.
REQ-043 Scenario: rst_n pulses low during SERVE_I, then a stray mem_resp arrives -> all outputs 0 asynchronously; no i_resp; state IDLE.
REQ-044 Scenario: d_read and d_write both high -> mem_write=1 and mem_read=0.
